// File: rtl/cam_capture_pkg.sv
// cam_capture_pkg
// Shared constants for the camera capture block: default camera data width,
// counter width, FSM state encodings and tag bit positions within a FIFO word.
// A FIFO word is laid out as {data[W_CAMD-1:0], eof, eol, sof}.
package cam_capture_pkg;

  // Camera data width minus one (UYVY: 16-bit words).
  localparam int W_CAMD_I = 15;
  // Width of the x/y position counters; matches the width/height ports.
  localparam int W1 = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_FRAME   = 2'd2
  } cap_state_t;

  localparam int TAG_SOF = 0;
  localparam int TAG_EOL = 1;
  localparam int TAG_EOF = 2;
  localparam int N_TAGS  = 3;

endpackage

// File: rtl/cam_fifo.sv
// cam_fifo
// Synchronous first-word-fall-through FIFO used as the output skid buffer.
// Pointers carry one extra MSB so full and empty are told apart without a
// separate count. A write while full is accepted only when a read happens in
// the same cycle (the freed slot is the one being written).
// Ports:
//   clk, rst        - clock, synchronous active-high reset (empties the FIFO)
//   wr_en, wr_data  - write request and word
//   rd_en           - pop the head word
//   rd_data         - head word, forced to zero while empty
//   full, empty     - status
module cam_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/cam_capture.sv
// cam_capture
// Captures a parallel camera stream (vsync/href/data) into framed pixel words
// with start-of-frame / end-of-line / end-of-frame tags, buffered in a small
// skid FIFO. The sensor is never stalled: words that do not fit are dropped
// and flagged.
// Ports:
//   cam_clk, cam_rst          - clock, synchronous active-high reset
//   cap_en                    - capture enable, sampled at the vsync falling edge
//   width, height             - expected words per line and lines per frame
//   cam_vsync/href/data       - sensor timing and data (vsync high = blanking)
//   pix_valid/ready/data      - output word stream
//   pix_sof/eol/eof           - tags, meaningful while pix_valid=1
//   frame_cnt                 - number of completed frames (wraps)
//   err_line/frame/ovf        - sticky errors, cleared by err_clr
//   state_dbg                 - current FSM state
//
// Handshake: a word transfers on a rising edge where pix_valid and pix_ready
// are both high. Once pix_valid is high it stays high, and pix_data and the
// tags stay unchanged, until that transfer happens.
module cam_capture
  import cam_capture_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int W_CAMD     = W_CAMD_I + 1
) (
  input  logic              cam_clk,
  input  logic              cam_rst,
  input  logic              cap_en,
  input  logic [15:0]       width,
  input  logic [15:0]       height,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [W_CAMD-1:0] cam_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [W_CAMD-1:0] pix_data,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_eof,
  output logic [31:0]       frame_cnt,
  output logic              err_line,
  output logic              err_frame,
  output logic              err_ovf,
  input  logic              err_clr,
  output logic [1:0]        state_dbg
);

  localparam int FW = W_CAMD + N_TAGS;

  // Input stage S1 plus one-cycle-delayed copies for edge detection.
  logic              s1_vs, s1_href, s1_vs_d, s1_href_d;
  logic [W_CAMD-1:0] s1_data;

  always_ff @(posedge cam_clk) begin
    if (cam_rst) begin
      s1_vs     <= 1'b0;
      s1_href   <= 1'b0;
      s1_data   <= '0;
      s1_vs_d   <= 1'b0;
      s1_href_d <= 1'b0;
    end else begin
      s1_vs     <= cam_vsync;
      s1_href   <= cam_href;
      s1_data   <= cam_data;
      s1_vs_d   <= s1_vs;
      s1_href_d <= s1_href;
    end
  end

  logic vs_fall, vs_rise, href_fall;
  assign vs_fall   = s1_vs_d && !s1_vs;
  assign vs_rise   = !s1_vs_d && s1_vs;
  assign href_fall = s1_href_d && !s1_href;

  cap_state_t state, state_nxt;
  logic       frame_start, frame_end;

  assign frame_start = (state == ST_WAIT_VS) && vs_fall && cap_en;
  assign frame_end   = (state == ST_FRAME) && vs_rise;
  assign state_dbg   = state;

  always_ff @(posedge cam_clk) begin
    if (cam_rst) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (s1_vs) state_nxt = ST_WAIT_VS;
      ST_WAIT_VS: if (frame_start) state_nxt = ST_FRAME;
      ST_FRAME:   if (frame_end) state_nxt = ST_WAIT_VS;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Position counters: x counts words within the line, y counts finished lines.
  logic [W1-1:0] x, y;

  always_ff @(posedge cam_clk) begin
    if (cam_rst || frame_start) begin
      x <= '0;
      y <= '0;
    end else if (state == ST_FRAME) begin
      if (href_fall) begin
        x <= '0;
        y <= y + W1'(1);
      end else if (s1_href) begin
        x <= x + W1'(1);
      end
    end
  end

  logic          push_req, pop, fifo_full, fifo_empty, ovf_set;
  logic          line_err_set, frame_err_set;
  logic          tag_sof, tag_eol, tag_eof;
  logic [FW-1:0] wr_word, rd_word;

  assign push_req = (state == ST_FRAME) && s1_href && (x < width) && (y < height);
  assign tag_sof  = (x == '0) && (y == '0);
  assign tag_eol  = (x == width - 16'd1);
  assign tag_eof  = tag_eol && (y == height - 16'd1);

  always_comb begin
    wr_word                  = '0;
    wr_word[FW-1:N_TAGS]     = s1_data;
    wr_word[TAG_SOF]         = tag_sof;
    wr_word[TAG_EOL]         = tag_eol;
    wr_word[TAG_EOF]         = tag_eof;
  end

  assign pop     = pix_valid && pix_ready;
  // A pop in the same cycle frees a slot, so only a push with no pop overflows.
  assign ovf_set = push_req && fifo_full && !pop;

  assign line_err_set  = (state == ST_FRAME) && href_fall && (x != width);
  assign frame_err_set = frame_end && (y != height);

  cam_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk     (cam_clk),
    .rst     (cam_rst),
    .wr_en   (push_req),
    .wr_data (wr_word),
    .rd_en   (pop),
    .rd_data (rd_word),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign pix_valid = !fifo_empty;
  assign pix_data  = rd_word[FW-1:N_TAGS];
  assign pix_sof   = rd_word[TAG_SOF];
  assign pix_eol   = rd_word[TAG_EOL];
  assign pix_eof   = rd_word[TAG_EOF];

  // Sticky flags; a clear in the same cycle as a new error wins.
  always_ff @(posedge cam_clk) begin
    if (cam_rst) begin
      frame_cnt <= '0;
      err_line  <= 1'b0;
      err_frame <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      if (frame_end) frame_cnt <= frame_cnt + 32'd1;
      err_line  <= err_clr ? 1'b0 : (err_line  || line_err_set);
      err_frame <= err_clr ? 1'b0 : (err_frame || frame_err_set);
      err_ovf   <= err_clr ? 1'b0 : (err_ovf   || ovf_set);
    end
  end

endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture
// Directed bench for cam_capture (width=8, height=2, FIFO_DEPTH=4). Expected
// output words are queued by each test before stimulus; a negedge monitor
// compares every transferred word against the queue head.
module tb_cam_capture;

  localparam int W  = 16;
  localparam int EW = W + 3;

  logic          cam_clk = 1'b0;
  logic          cam_rst, cap_en, cam_vsync, cam_href, pix_ready, err_clr;
  logic [15:0]   width, height;
  logic [W-1:0]  cam_data;
  logic          pix_valid, pix_sof, pix_eol, pix_eof;
  logic [W-1:0]  pix_data;
  logic [31:0]   frame_cnt;
  logic          err_line, err_frame, err_ovf;
  logic [1:0]    state_dbg;

  logic [EW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;

  // ---------------- clock / reset ----------------
  always #5 cam_clk = ~cam_clk;

  cam_capture #(.FIFO_DEPTH(4), .W_CAMD(W)) dut (
    .cam_clk   (cam_clk),
    .cam_rst   (cam_rst),
    .cap_en    (cap_en),
    .width     (width),
    .height    (height),
    .cam_vsync (cam_vsync),
    .cam_href  (cam_href),
    .cam_data  (cam_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .pix_sof   (pix_sof),
    .pix_eol   (pix_eol),
    .pix_eof   (pix_eof),
    .frame_cnt (frame_cnt),
    .err_line  (err_line),
    .err_frame (err_frame),
    .err_ovf   (err_ovf),
    .err_clr   (err_clr),
    .state_dbg (state_dbg)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected word: data = {line, x}; tags given by the frame geometry.
  function automatic logic [EW-1:0] mk_word(input int ln, input int x, input bit sof,
                                            input bit eol, input bit eof);
    logic [W-1:0] d;
    d = W'((ln << 8) | x);
    return {d, eof, eol, sof};
  endfunction

  task automatic exp_line(input int ln, input int n, input int w, input int h);
    for (int x = 0; x < n; x++)
      exp_q.push_back(mk_word(ln, x, (x == 0) && (ln == 0), x == w - 1,
                              (x == w - 1) && (ln == h - 1)));
  endtask

  // Scoreboard monitor: a transfer happens at the next posedge.
  always @(negedge cam_clk) begin
    if (pix_valid && pix_ready) begin
      if (exp_q.size() == 0)
        check("pix_extra_word", 32'(exp_q.size()), 32'd1);
      else
        check("pix_word", 32'({pix_data, pix_eof, pix_eol, pix_sof}), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge cam_clk);
      #1;
    end
  endtask

  task automatic send_line(input int ln, input int n);
    for (int x = 0; x < n; x++) begin
      cam_href = 1'b1;
      cam_data = W'((ln << 8) | x);
      step(1);
    end
    cam_href = 1'b0;
    step(4);
  endtask

  task automatic vs_fall(input bit en);
    cap_en    = en;
    cam_vsync = 1'b0;
    step(3);
  endtask

  task automatic end_frame();
    cam_vsync = 1'b1;
    step(4);
  endtask

  task automatic clr_pulse();
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step(1);
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    cam_rst = 1'b1; cap_en = 1'b0; width = 16'd8; height = 16'd2;
    cam_vsync = 1'b0; cam_href = 1'b0; cam_data = '0; pix_ready = 1'b1; err_clr = 1'b0;
    step(3);
    check("rst_valid", 32'(pix_valid), 32'd0);
    check("rst_data", 32'(pix_data), 32'd0);
    check("rst_tags", 32'({pix_sof, pix_eol, pix_eof}), 32'd0);
    check("rst_frame_cnt", frame_cnt, 32'd0);
    check("rst_errs", 32'({err_line, err_frame, err_ovf}), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    cam_rst = 1'b0;

    // Basic frame, preceded by 8 href pulses during vsync blanking.
    cam_vsync = 1'b1;
    step(4);
    check("t1_wait_vs", 32'(state_dbg), 32'd1);
    for (int l = 0; l < 8; l++) send_line(9, 8);
    check("t1_blank_ignored", 32'(pix_valid), 32'd0);
    vs_fall(1'b1);
    check("t1_in_frame", 32'(state_dbg), 32'd2);
    exp_line(0, 8, 8, 2);
    exp_line(1, 8, 8, 2);
    cam_href = 1'b1; cam_data = 16'h0000;
    step(1);
    check("t1_lat_1cyc", 32'(pix_valid), 32'd0);
    cam_data = 16'h0001;
    step(1);
    check("t1_lat_2cyc", 32'(pix_valid), 32'd1);
    for (int x = 2; x < 8; x++) begin
      cam_data = W'(x);
      step(1);
    end
    cam_href = 1'b0;
    step(4);
    send_line(1, 8);
    end_frame();
    wait_drain("t1_drain", 50);
    check("t1_frame_cnt", frame_cnt, 32'd1);
    check("t1_errs", 32'({err_line, err_frame, err_ovf}), 32'd0);
    check("t1_state", 32'(state_dbg), 32'd1);

    // Overflow: ready low for a whole line keeps only the first 4 words.
    pix_ready = 1'b0;
    vs_fall(1'b1);
    exp_line(0, 4, 8, 2);
    send_line(0, 8);
    check("t2_ovf", 32'(err_ovf), 32'd1);
    check("t2_valid", 32'(pix_valid), 32'd1);
    check("t2_hold_a", 32'({pix_data, pix_eof, pix_eol, pix_sof}), 32'h1);
    step(3);
    check("t2_hold_b", 32'({pix_data, pix_eof, pix_eol, pix_sof}), 32'h1);
    pix_ready = 1'b1;
    wait_drain("t2_drain", 20);
    check("t2_empty", 32'(pix_valid), 32'd0);
    exp_line(1, 8, 8, 2);
    send_line(1, 8);
    end_frame();
    wait_drain("t2_drain2", 20);
    check("t2_frame_cnt", frame_cnt, 32'd2);
    check("t2_line_frame", 32'({err_line, err_frame}), 32'd0);
    clr_pulse();
    check("t2_ovf_clr", 32'(err_ovf), 32'd0);

    // Short line.
    vs_fall(1'b1);
    exp_line(0, 7, 8, 2);
    send_line(0, 7);
    check("t3_err_line", 32'(err_line), 32'd1);
    clr_pulse();
    check("t3_err_line_clr", 32'(err_line), 32'd0);
    exp_line(1, 8, 8, 2);
    send_line(1, 8);
    end_frame();
    wait_drain("t3_drain", 20);
    check("t3_errs", 32'({err_line, err_frame, err_ovf}), 32'd0);
    check("t3_frame_cnt", frame_cnt, 32'd3);

    // Too many lines: third line dropped, err_frame set.
    vs_fall(1'b1);
    exp_line(0, 8, 8, 2);
    exp_line(1, 8, 8, 2);
    send_line(0, 8);
    send_line(1, 8);
    send_line(2, 8);
    end_frame();
    wait_drain("t4_drain", 20);
    check("t4_err_frame", 32'(err_frame), 32'd1);
    check("t4_err_line", 32'(err_line), 32'd0);
    check("t4_frame_cnt", frame_cnt, 32'd4);
    clr_pulse();
    check("t4_frame_clr", 32'(err_frame), 32'd0);

    // Clear held across the frame end wins over the error set.
    vs_fall(1'b1);
    exp_line(0, 8, 8, 2);
    exp_line(1, 8, 8, 2);
    send_line(0, 8);
    send_line(1, 8);
    send_line(2, 8);
    err_clr = 1'b1;
    end_frame();
    err_clr = 1'b0;
    step(1);
    wait_drain("t5_drain", 20);
    check("t5_clr_priority", 32'(err_frame), 32'd0);
    check("t5_frame_cnt", frame_cnt, 32'd5);

    // Capture disabled at vsync fall: frame skipped, next one captured.
    vs_fall(1'b0);
    send_line(0, 8);
    send_line(1, 8);
    end_frame();
    check("t6_skip_cnt", frame_cnt, 32'd5);
    check("t6_skip_valid", 32'(pix_valid), 32'd0);
    vs_fall(1'b1);
    exp_line(0, 8, 8, 2);
    exp_line(1, 8, 8, 2);
    send_line(0, 8);
    send_line(1, 8);
    end_frame();
    wait_drain("t6_drain", 20);
    check("t6_frame_cnt", frame_cnt, 32'd6);

    // width == 0: nothing pushed, lines flagged, line count still matches.
    width = 16'd0;
    vs_fall(1'b1);
    send_line(0, 8);
    send_line(1, 8);
    end_frame();
    check("t7_w0_valid", 32'(pix_valid), 32'd0);
    check("t7_w0_errs", 32'({err_line, err_frame, err_ovf}), 32'b100);
    check("t7_frame_cnt", frame_cnt, 32'd7);
    clr_pulse();
    width = 16'd8;

    // Reset mid-line with 3 words buffered.
    pix_ready = 1'b0;
    vs_fall(1'b1);
    for (int x = 0; x < 4; x++) begin
      cam_href = 1'b1;
      cam_data = W'(x);
      step(1);
    end
    check("t8_pre_valid", 32'(pix_valid), 32'd1);
    cam_rst = 1'b1;
    cam_data = 16'h0004;
    step(1);
    check("t8_rst_valid", 32'(pix_valid), 32'd0);
    cam_rst = 1'b0;
    pix_ready = 1'b1;
    for (int x = 5; x < 9; x++) begin
      cam_data = W'(x);
      step(1);
    end
    cam_href = 1'b0;
    step(4);
    check("t8_no_out", 32'(pix_valid), 32'd0);
    check("t8_frame_cnt", frame_cnt, 32'd0);
    check("t8_state_idle", 32'(state_dbg), 32'd0);
    cam_vsync = 1'b1;
    step(4);
    check("t8_state_wait", 32'(state_dbg), 32'd1);
    vs_fall(1'b1);
    exp_line(0, 8, 8, 2);
    exp_line(1, 8, 8, 2);
    send_line(0, 8);
    send_line(1, 8);
    end_frame();
    wait_drain("t8_drain", 20);
    check("t8_frame_cnt2", frame_cnt, 32'd1);
    check("t8_errs", 32'({err_line, err_frame, err_ovf}), 32'd0);

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
